dmem_ctrl: RTL and testbench

Data-memory controller placed directly downstream of the CPU's dmem port group. It turns CPU load/store requests (address, width code, read/write strobes, store data) into accesses on a word-wide synchronous SRAM. That SRAM has one-cycle read latency and no byte enables. The controller extracts sub-word load data, performs read-modify-write for `sb`/`sh`, and raises `stall` so the CPU can gate its PC enable.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_lane.sv | 21 ++
 rtl/dmem_ctrl.sv | 110 +++++++++++
 tb/tb_dmem_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared width codes, base address and FSM state type for the data-memory controller
package dmem_pkg;
   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;
   localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
   typedef enum logic [1:0] {IDLE, LOAD_RESP, STORE_MERGE} dmem_state_t;
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: little-endian lane extraction for loads and lane merge for sub-word stores
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [1:0]  width,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] merged
);
   logic [4:0]  shamt;
   logic [31:0] mask;
   // lane bit offset and mask; any code other than word or half behaves as a byte
   always_comb begin
      shamt  = width == WIDTH_WORD ? 5'd0 : width == WIDTH_HALF ? {addr[1], 4'b0} : {addr, 3'b0};
      mask   = width == WIDTH_WORD ? 32'hFFFF_FFFF : width == WIDTH_HALF ? 32'h0000_FFFF : 32'h0000_00FF;
      rdata  = (word >> shamt) & mask;
      merged = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
   end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: CPU load/store front end for a word-wide one-cycle-latency SRAM with sub-word read-modify-write
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int          ADDR_W    = 11,
   parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR
)(
   input  logic              clk_in,
   input  logic              rst,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [1:0]        cpu_width,
   input  logic              cpu_w,
   input  logic              cpu_r,
   output logic [31:0]       cpu_rdata,
   output logic              stall,
   output logic              addr_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);
   dmem_state_t       state, state_nxt;
   logic [ADDR_W-1:0] idx, hold_idx;
   logic [1:0]        hold_off, hold_width;
   logic [31:0]       hold_wdata, lane_rdata, lane_merged;
   logic              req, err, issue;
   assign idx = ADDR_W'((cpu_addr - BASE_ADDR) >> 2);
   assign req = cpu_r | cpu_w;
   assign err = (cpu_r & cpu_w) | (cpu_width == WIDTH_WORD && cpu_addr[1:0] != 2'b00) | (cpu_width == WIDTH_HALF && cpu_addr[0]);
   dmem_lane u_lane (
      .word   (ram_rdata),
      .addr   (hold_off),
      .width  (hold_width),
      .wdata  (hold_wdata),
      .rdata  (lane_rdata),
      .merged (lane_merged)
   );
   // state register; the request is latched when an SRAM read is issued so the CPU inputs may drift while stalled
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         hold_idx   <= '0;
         hold_off   <= '0;
         hold_width <= '0;
         hold_wdata <= '0;
      end else begin
         state <= state_nxt;
         if (issue) begin
            hold_idx   <= idx;
            hold_off   <= cpu_addr[1:0];
            hold_width <= cpu_width;
            hold_wdata <= cpu_wdata;
         end
      end
   end
   // next state and outputs; everything is held low while reset is asserted so a pending merge never writes
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      stall     = 1'b0;
      addr_err  = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      cpu_rdata = '0;
      case (state)
         IDLE: begin
            if (req && err) begin
               addr_err = 1'b1;
            end else if (cpu_w && cpu_width == WIDTH_WORD) begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = idx;
               ram_wdata = cpu_wdata;
            end else if (req) begin
               issue     = 1'b1;
               stall     = 1'b1;
               ram_en    = 1'b1;
               ram_addr  = idx;
               state_nxt = cpu_r ? LOAD_RESP : STORE_MERGE;
            end
         end
         LOAD_RESP: begin
            cpu_rdata = lane_rdata;
            state_nxt = IDLE;
         end
         STORE_MERGE: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = hold_idx;
            ram_wdata = lane_merged;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!rst) begin
         issue     = 1'b0;
         stall     = 1'b0;
         addr_err  = 1'b0;
         ram_en    = 1'b0;
         ram_we    = 1'b0;
         ram_addr  = '0;
         ram_wdata = '0;
         cpu_rdata = '0;
      end
   end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench with a byte-lane reference memory for the data-memory controller
module tb_dmem_ctrl;
   localparam int          ADDR_W = 11;
   localparam logic [31:0] BASE   = 32'h1001_0000;
   logic              clk_in = 1'b0, rst = 1'b0;
   logic [31:0]       cpu_addr = '0, cpu_wdata = '0;
   logic [1:0]        cpu_width = '0;
   logic              cpu_w = 1'b0, cpu_r = 1'b0;
   logic [31:0]       cpu_rdata, ram_wdata;
   logic              stall, addr_err, ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_rdata = '0;
   logic [31:0]       sram    [2048];
   logic [31:0]       ref_mem [2048];
   typedef struct {bit is_err; logic [31:0] data;} exp_t;
   exp_t exp_q[$];
   exp_t e;
   int   n_tests = 0, n_fail = 0;
   logic prev_load = 1'b0;

   always #5 clk_in = ~clk_in;

   dmem_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_width (cpu_width),
      .cpu_w     (cpu_w),
      .cpu_r     (cpu_r),
      .cpu_rdata (cpu_rdata),
      .stall     (stall),
      .addr_err  (addr_err),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // synchronous SRAM with one-cycle read latency
   always @(posedge clk_in) begin
      if (ram_en) begin
         if (ram_we) sram[ram_addr] <= ram_wdata;
         ram_rdata <= sram[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off, input logic [1:0] wd);
      if (wd == 2'b10) return w;
      if (wd == 2'b01) return off[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      return {24'h0, w[8*off +: 8]};
   endfunction

   task automatic ref_store(input int unsigned idx, input logic [1:0] off, input logic [1:0] wd, input logic [31:0] d);
      logic [31:0] w;
      w = ref_mem[idx];
      if (wd == 2'b10) w = d;
      else if (wd == 2'b01) w[16*off[1] +: 16] = d[15:0];
      else w[8*off +: 8] = d[7:0];
      ref_mem[idx] = w;
   endtask

   // monitor: load data the cycle after a stalled load, addr_err pulses, and cpu_rdata quiet otherwise
   always @(negedge clk_in) begin
      if (rst) begin
         if (prev_load) begin
            if (exp_q.size() != 0 && !exp_q[0].is_err) begin
               e = exp_q.pop_front();
               chk("load_data", cpu_rdata, e.data);
            end else begin
               n_tests++;
               n_fail++;
               $display("FAIL load_resp: unexpected load response %h", cpu_rdata);
            end
         end else chk("rdata_quiet", cpu_rdata, 32'h0);
         n_tests++;
         if (addr_err) begin
            if (exp_q.size() != 0 && exp_q[0].is_err) void'(exp_q.pop_front());
            else begin
               n_fail++;
               $display("FAIL addr_err: got 1 expected 0");
            end
            chk("err_ram_en", ram_en, 32'h0);
            chk("err_stall", stall, 32'h0);
         end else if (exp_q.size() != 0 && exp_q[0].is_err) begin
            n_fail++;
            $display("FAIL addr_err: got 0 expected 1");
            void'(exp_q.pop_front());
         end
         prev_load <= stall & cpu_r;
      end else prev_load <= 1'b0;
   end

   task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [1:0] wd, input logic [31:0] d);
      int unsigned idx;
      bit err;
      int stalls, exp_st;
      idx = ((a - BASE) >> 2) % 2048;
      err = (r && w) || (wd == 2'b10 && a[1:0] != 2'b00) || (wd == 2'b01 && a[0]);
      exp_st = (err || (w && wd == 2'b10)) ? 0 : 1;
      @(posedge clk_in);
      #1;
      cpu_r = r;
      cpu_w = w;
      cpu_addr = a;
      cpu_width = wd;
      cpu_wdata = d;
      if (err) exp_q.push_back('{is_err: 1'b1, data: 32'h0});
      else if (r) exp_q.push_back('{is_err: 1'b0, data: ref_load(ref_mem[idx], a[1:0], wd)});
      else ref_store(idx, a[1:0], wd, d);
      @(negedge clk_in);
      chk("ram_en", ram_en, {31'h0, !err});
      if (!err) begin
         chk("ram_addr", ram_addr, idx);
         chk("ram_we", ram_we, {31'h0, exp_st == 0});
      end
      stalls = 0;
      while (stall && stalls < 4) begin
         stalls++;
         @(negedge clk_in);
      end
      chk("stall_cycles", stalls, exp_st);
   endtask

   task automatic idle();
      @(posedge clk_in);
      #1;
      cpu_r = 1'b0;
      cpu_w = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2048; i++) begin
         sram[i] = '0;
         ref_mem[i] = '0;
      end
      cpu_w = 1'b1;
      cpu_width = 2'b10;
      cpu_addr = BASE;
      cpu_wdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk_in);
      chk("rst_ram_en", ram_en, 32'h0);
      chk("rst_ram_we", ram_we, 32'h0);
      chk("rst_stall", stall, 32'h0);
      chk("rst_addr_err", addr_err, 32'h0);
      chk("rst_ram_wdata", ram_wdata, 32'h0);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      cpu_w = 1'b0;
      @(posedge clk_in);
      #3 rst = 1'b1;
      do_req(0, 1, BASE + 32'h8, 2'b10, 32'hDEAD_BEEF);
      do_req(1, 0, BASE + 32'h8, 2'b10, 32'h0);
      idle();
      chk("sw_word2", sram[2], 32'hDEAD_BEEF);
      do_req(0, 1, BASE + 32'hA, 2'b00, 32'h0000_0055);
      idle();
      chk("sb_word2", sram[2], 32'hDE55_BEEF);
      do_req(1, 0, BASE + 32'hA, 2'b00, 32'h0);
      do_req(0, 1, BASE + 32'h2, 2'b01, 32'h0000_1234);
      do_req(1, 0, BASE + 32'h2, 2'b01, 32'h0);
      idle();
      chk("sh_word0", sram[0], 32'h1234_0000);
      do_req(1, 0, BASE + 32'h1, 2'b10, 32'h0);
      do_req(0, 1, BASE + 32'h3, 2'b01, 32'h0);
      do_req(1, 1, BASE + 32'h4, 2'b00, 32'h0);
      idle();
      @(posedge clk_in);
      #1;
      cpu_w = 1'b1;
      cpu_width = 2'b00;
      cpu_addr = BASE + 32'h9;
      cpu_wdata = 32'h0000_0077;
      @(posedge clk_in);
      #1;
      rst = 1'b0;
      cpu_w = 1'b0;
      #1;
      chk("mid_rst_ram_en", ram_en, 32'h0);
      chk("mid_rst_ram_we", ram_we, 32'h0);
      chk("mid_rst_ram_wdata", ram_wdata, 32'h0);
      chk("mid_rst_stall", stall, 32'h0);
      chk("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
      repeat (2) @(posedge clk_in);
      #3 rst = 1'b1;
      chk("mid_rst_word2", sram[2], 32'hDE55_BEEF);
      do_req(1, 0, BASE + 32'h9, 2'b00, 32'h0);
      do_req(1, 0, BASE + 32'h2000, 2'b10, 32'h0);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         int k;
         a = BASE + $urandom_range(0, 63) + (($urandom_range(0, 3) == 0) ? 32'h2000 : 32'h0);
         k = $urandom_range(0, 9);
         do_req(k < 4 || k == 9, k >= 4, a, 2'($urandom_range(0, 3)), $urandom);
         if ($urandom_range(0, 7) == 0) idle();
      end
      idle();
      repeat (2) @(negedge clk_in);
      chk("queue_empty", exp_q.size(), 32'h0);
      for (int i = 0; i < 16; i++) chk("mem_word", sram[i], ref_mem[i]);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
